alu_operand_loader: RTL and testbench

Sequential front end that produces the operands and opcode consumed by the 4-bit ALU. One shared switch bank and a load button enter A, then B, then the 6-bit opcode, one per press. The block holds them stable on its outputs and flags when a complete operation is presented. It sits between the board I/O (switches, push buttons) and the ALU's A/B/Op inputs; the ALU result goes straight to the LEDs outside this block.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/button_debouncer.sv | 55 +++++
 rtl/alu_operand_loader.sv | 100 ++++++++++
 tb/tb_alu_operand_loader.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand loader and its users.
// Holds the FSM state encodings and the ALU opcode constants.
package alu_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned ALU_OP_W = 6;

  typedef enum logic [STATE_W-1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_OP  = 2'b10,
    S_RUN = 2'b11
  } state_t;

  localparam logic [ALU_OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [ALU_OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [ALU_OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [ALU_OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [ALU_OP_W-1:0] OP_SRL = 6'b000010;
  localparam logic [ALU_OP_W-1:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/button_debouncer.sv
// One button path: 2-flop synchronizer, stability counter, rising-edge pulse.
// pulse_c is a one-cycle strobe decoded from two registers.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Level toggles on the edge after the counter has seen DEBOUNCE_CYCLES differing cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign pulse_c = level & ~level_d;

endmodule

// File: rtl/alu_operand_loader.sv
// Loads ALU operand A, operand B and the opcode from a shared switch bank,
// one per debounced load press; a clear press zeroes everything.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W          = 4,
  parameter int unsigned OP_W            = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   sw,
  input  logic              btn_load,
  input  logic              btn_clr,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [OP_W-1:0]   op_out,
  output logic [1:0]        state_out,
  output logic              valid
);

  logic load_p;
  logic clr_p;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] a_nxt;
  logic [DATA_W-1:0] b_nxt;
  logic [OP_W-1:0]   op_nxt;
  logic              valid_nxt;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn_load),
    .pulse_c (load_p)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn_clr),
    .pulse_c (clr_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_A;
      a_out  <= '0;
      b_out  <= '0;
      op_out <= '0;
      valid  <= 1'b0;
    end else begin
      state  <= state_nxt;
      a_out  <= a_nxt;
      b_out  <= b_nxt;
      op_out <= op_nxt;
      valid  <= valid_nxt;
    end
  end

  // Clear has priority over a coincident load.
  always_comb begin
    state_nxt = state;
    a_nxt     = a_out;
    b_nxt     = b_out;
    op_nxt    = op_out;
    valid_nxt = valid;
    if (clr_p) begin
      state_nxt = S_A;
      a_nxt     = '0;
      b_nxt     = '0;
      op_nxt    = '0;
      valid_nxt = 1'b0;
    end else if (load_p) begin
      case (state)
        S_A: begin
          a_nxt     = sw[DATA_W-1:0];
          state_nxt = S_B;
        end
        S_B: begin
          b_nxt     = sw[DATA_W-1:0];
          state_nxt = S_OP;
        end
        S_OP: begin
          op_nxt    = sw[OP_W-1:0];
          valid_nxt = 1'b1;
          state_nxt = S_RUN;
        end
        default: begin
          valid_nxt = 1'b0;
          state_nxt = S_A;
        end
      endcase
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a short debounce window.
module tb_alu_operand_loader;
  import alu_pkg::*;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned DB     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [OP_W-1:0]   sw;
  logic              btn_load;
  logic              btn_clr;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic [OP_W-1:0]   op_out;
  logic [1:0]        state_out;
  logic              valid;

  int checks = 0;
  int errors = 0;

  alu_operand_loader #(
    .DATA_W(DATA_W), .OP_W(OP_W), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_load(btn_load), .btn_clr(btn_clr),
    .a_out(a_out), .b_out(b_out), .op_out(op_out), .state_out(state_out), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Press held long enough to be accepted and acted on, then released and settled.
  task automatic press(input logic do_load, input logic do_clr, input logic [OP_W-1:0] val);
    @(negedge clk);
    sw       = val;
    btn_load = do_load;
    btn_clr  = do_clr;
    repeat (DB + 3) @(posedge clk);
    @(negedge clk);
    btn_load = 1'b0;
    btn_clr  = 1'b0;
    repeat (DB + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; sw = '0; btn_load = 1'b0; btn_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_a", 32'(a_out), 32'h0);
    check("rst_b", 32'(b_out), 32'h0);
    check("rst_op", 32'(op_out), 32'h0);
    check("rst_state", 32'(state_out), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);

    // Full sequence
    press(1'b1, 1'b0, 6'b000011);
    check("seq_a1", 32'(a_out), 32'h3);
    check("seq_st1", 32'(state_out), 32'h1);
    press(1'b1, 1'b0, 6'b000101);
    check("seq_st2", 32'(state_out), 32'h2);
    check("seq_valid2", 32'(valid), 32'h0);
    press(1'b1, 1'b0, OP_ADD);
    check("seq_a", 32'(a_out), 32'h3);
    check("seq_b", 32'(b_out), 32'h5);
    check("seq_op", 32'(op_out), 32'h20);
    check("seq_valid", 32'(valid), 32'h1);
    check("seq_state", 32'(state_out), 32'h3);

    // Wrap back to S_A keeps registers
    press(1'b1, 1'b0, 6'b111111);
    check("wrap_valid", 32'(valid), 32'h0);
    check("wrap_state", 32'(state_out), 32'h0);
    check("wrap_a", 32'(a_out), 32'h3);
    check("wrap_b", 32'(b_out), 32'h5);
    check("wrap_op", 32'(op_out), 32'h20);
    press(1'b1, 1'b0, 6'b111001);
    check("wrap_a9", 32'(a_out), 32'h9);
    check("wrap_st1", 32'(state_out), 32'h1);

    // Clear mid-sequence
    press(1'b0, 1'b1, 6'b000000);
    press(1'b1, 1'b0, 6'b001010);
    check("clr_pre_a", 32'(a_out), 32'hA);
    check("clr_pre_st", 32'(state_out), 32'h1);
    press(1'b0, 1'b1, 6'b111111);
    check("clr_a", 32'(a_out), 32'h0);
    check("clr_b", 32'(b_out), 32'h0);
    check("clr_op", 32'(op_out), 32'h0);
    check("clr_valid", 32'(valid), 32'h0);
    check("clr_state", 32'(state_out), 32'h0);
    press(1'b1, 1'b1, 6'b001111);
    check("clrld_state", 32'(state_out), 32'h0);
    check("clrld_a", 32'(a_out), 32'h0);

    // Bounce rejection
    @(negedge clk);
    sw = 6'b000110;
    for (int i = 0; i < 10; i++) begin
      btn_load = ~btn_load;
      repeat (2) @(negedge clk);
    end
    btn_load = 1'b0;
    repeat (DB + 6) @(posedge clk); #1;
    check("bnc_state", 32'(state_out), 32'h0);
    check("bnc_a", 32'(a_out), 32'h0);
    press(1'b1, 1'b0, 6'b000111);
    check("bnc_clean_st", 32'(state_out), 32'h1);
    check("bnc_clean_a", 32'(a_out), 32'h7);

    // Latency: first sampled at edge k, update at k+7
    press(1'b0, 1'b1, 6'b000000);
    @(negedge clk);
    sw = 6'b001100;
    btn_load = 1'b1;
    repeat (7) @(posedge clk); #1;   // edges k .. k+6
    check("lat_k6_a", 32'(a_out), 32'h0);
    check("lat_k6_st", 32'(state_out), 32'h0);
    @(posedge clk); #1;              // edge k+7
    check("lat_k7_a", 32'(a_out), 32'hC);
    check("lat_k7_st", 32'(state_out), 32'h1);
    @(negedge clk);
    btn_load = 1'b0;
    repeat (DB + 4) @(posedge clk); #1;

    // Async reset mid-debounce, between edges
    @(negedge clk);
    sw = 6'b000101;
    btn_load = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_a", 32'(a_out), 32'h0);
    check("arst_state", 32'(state_out), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (6) @(posedge clk); #1;   // edges k .. k+5 after release
    check("arst_hold_st", 32'(state_out), 32'h0);
    check("arst_hold_a", 32'(a_out), 32'h0);
    repeat (3) @(posedge clk); #1;   // through k+8
    check("arst_acc_st", 32'(state_out), 32'h1);
    check("arst_acc_a", 32'(a_out), 32'h5);
    @(negedge clk);
    btn_load = 1'b0;
    repeat (DB + 4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
